// File: rtl/npc_pkg.sv
// Shared types and constants for the npc core front end.
//   XLEN          : datapath width
//   NPC_RESET_PC  : first fetch address after reset
//   ifu_state_e   : fetch-unit controller states
//   word_align()  : clears the byte-offset bits of an address
package npc_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NPC_RESET_PC = 32'h8000_0000;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      DROP = 3'd4
   } ifu_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction-fetch initiator. Owns the PC, issues one word read at a time to
// instruction memory, and hands each returned word (tagged with its PC) to
// decode. Redirects from execute replace the PC; a response belonging to a
// request issued before the redirect is absorbed and counted, never forwarded.
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   mem_req_valid/ready   : request handshake, mem_req_addr is word aligned
//   mem_resp_valid/ready  : response handshake, mem_resp_rdata is the word
//   redirect_valid/pc     : single-cycle redirect pulse and target
//   inst_valid/ready      : handshake to decode, inst_pc/inst are registered
//   drop_cnt              : wrapping count of discarded stale responses
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | request presented, waiting for mem_req_ready
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction presented to decode
// DROP  | waiting for a stale response to discard
module ifu_fetch
   import npc_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = NPC_RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_resp_valid,
   output logic            mem_resp_ready,
   input  logic [XLEN-1:0] mem_resp_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst,
   output logic [15:0]     drop_cnt
);

   ifu_state_e      state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] redirect_tgt;

   assign redirect_tgt = word_align(redirect_pc);

   // Outputs decode straight from the state flop, no combinational input path.
   assign mem_req_valid  = (state == REQ);
   assign mem_resp_ready = (state == WAIT) || (state == DROP);
   assign inst_valid     = (state == HOLD);
   assign mem_req_addr   = word_align(pc);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         inst     <= '0;
         inst_pc  <= '0;
         drop_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (redirect_valid) pc <= redirect_tgt;
               state <= REQ;
            end

            REQ: begin
               if (redirect_valid) begin
                  pc <= redirect_tgt;
                  // An accepted request is already in flight; its data is stale.
                  if (mem_req_ready) state <= DROP;
               end else if (mem_req_ready) begin
                  state <= WAIT;
               end
            end

            WAIT: begin
               if (redirect_valid) begin
                  pc <= redirect_tgt;
                  if (mem_resp_valid) begin
                     drop_cnt <= drop_cnt + 16'd1;
                     state    <= REQ;
                  end else begin
                     state <= DROP;
                  end
               end else if (mem_resp_valid) begin
                  inst    <= mem_resp_rdata;
                  inst_pc <= pc;
                  state   <= HOLD;
               end
            end

            HOLD: begin
               // A coincident inst_ready is still a consumption, but the
               // redirect target wins over pc+4.
               if (redirect_valid) begin
                  pc    <= redirect_tgt;
                  state <= REQ;
               end else if (inst_ready) begin
                  pc    <= pc + XLEN'(4);
                  state <= REQ;
               end
            end

            DROP: begin
               if (redirect_valid) pc <= redirect_tgt;
               if (mem_resp_valid) begin
                  drop_cnt <= drop_cnt + 16'd1;
                  state    <= REQ;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
   import npc_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_resp_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_pc;
   logic [31:0] inst;
   logic [15:0] drop_cnt;

   ifu_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_ready (mem_resp_ready),
      .mem_resp_rdata (mem_resp_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_pc        (inst_pc),
      .inst           (inst),
      .drop_cnt       (drop_cnt)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } inst_exp_t;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int inst_cnt = 0;
   int resp_delay = 1;
   bit mem_flush = 0;

   logic [31:0] req_q[$];
   inst_exp_t   inst_q[$];
   int          inst_cyc_q[$];

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Instruction memory contents: the word returned at 8000_0000 is 0000_0413.
   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], 16'h0413};
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: response pulse resp_delay cycles after each handshake.
   initial begin
      int          cnt;
      logic [31:0] pend;
      cnt = 0;
      pend = '0;
      mem_resp_valid = 0;
      mem_resp_rdata = '0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 0;
         if (mem_flush) begin
            cnt = 0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               mem_resp_valid = 1;
               mem_resp_rdata = mem_data(pend);
            end
         end
         #3;
         if (mem_req_valid && mem_req_ready && rst_n && !mem_flush) begin
            cnt  = resp_delay;
            pend = mem_req_addr;
         end
      end
   end

   // Scoreboard monitor: pops an expectation at every handshake the DUT makes.
   initial forever begin
      @(negedge clk);
      #2;
      if (mem_req_valid && mem_req_ready) begin
         if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got addr %h, none expected", mem_req_addr);
         end else begin
            check32("req_addr", mem_req_addr, req_q.pop_front());
         end
      end
      if (inst_valid && inst_ready) begin
         inst_cyc_q.push_back(cyc);
         inst_cnt++;
         if (inst_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL inst_unexpected: got pc %h inst %h, none expected", inst_pc, inst);
         end else begin
            inst_exp_t e;
            e = inst_q.pop_front();
            check32("inst_pc", inst_pc, e.pc);
            check32("inst", inst, e.data);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // sel: 0 inst_valid, 1 mem_resp_ready, 2 mem_resp_valid, 3 inst_cnt >= target
   task automatic wait_for(input int sel, input int target, input string name);
      int  n;
      bit  hit;
      n = 0;
      hit = 0;
      while (!hit) begin
         step();
         case (sel)
            0: hit = inst_valid;
            1: hit = mem_resp_ready;
            2: hit = mem_resp_valid;
            default: hit = (inst_cnt >= target);
         endcase
         n++;
         if (!hit && n > 200) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got no event in %0d cycles, required one", name, n);
            hit = 1;
         end
      end
   endtask

   task automatic expect_fetch(input logic [31:0] a);
      inst_exp_t e;
      e.pc   = a;
      e.data = mem_data(a);
      req_q.push_back(a);
      inst_q.push_back(e);
   endtask

   initial begin
      int base;
      rst_n          = 0;
      mem_req_ready  = 0;
      redirect_valid = 0;
      redirect_pc    = '0;
      inst_ready     = 0;

      // Reset values
      repeat (3) step();
      check32("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      check32("rst_resp_ready", {31'd0, mem_resp_ready}, 32'd0);
      check32("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check32("rst_inst", inst, 32'd0);
      check32("rst_inst_pc", inst_pc, 32'd0);
      check32("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      check32("rst_addr", mem_req_addr, 32'h8000_0000);

      // Zero-wait streaming from RESET_PC
      expect_fetch(32'h8000_0000);
      expect_fetch(32'h8000_0004);
      expect_fetch(32'h8000_0008);
      mem_req_ready = 1;
      inst_ready    = 1;
      rst_n         = 1;
      step();
      check32("first_req_valid", {31'd0, mem_req_valid}, 32'd1);
      wait_for(3, 3, "stream");
      mem_req_ready = 0;
      if (inst_cyc_q.size() >= 3) begin
         check32("throughput_0", inst_cyc_q[1] - inst_cyc_q[0], 32'd3);
         check32("throughput_1", inst_cyc_q[2] - inst_cyc_q[1], 32'd3);
      end else begin
         checks++;
         errors++;
         $display("FAIL throughput: got %0d instructions, required 3", inst_cyc_q.size());
      end

      // Decode stall for 5 cycles in HOLD
      expect_fetch(32'h8000_000C);
      mem_req_ready = 1;
      inst_ready    = 0;
      wait_for(0, 0, "stall_hold");
      mem_req_ready = 0;
      for (int i = 0; i < 5; i++) begin
         check32("stall_inst", inst, 32'h000C_0413);
         check32("stall_inst_pc", inst_pc, 32'h8000_000C);
         check32("stall_no_req", {31'd0, mem_req_valid}, 32'd0);
         step();
      end
      inst_ready = 1;
      step();
      check32("post_stall_valid", {31'd0, mem_req_valid}, 32'd1);
      check32("post_stall_addr", mem_req_addr, 32'h8000_0010);

      // Redirect during WAIT, stale response three cycles after the request
      base = inst_cnt;
      req_q.push_back(32'h8000_0010);
      expect_fetch(32'h8000_0100);
      resp_delay    = 3;
      mem_req_ready = 1;
      wait_for(1, 0, "wait_redirect");
      redirect_valid = 1;
      redirect_pc    = 32'h8000_0103;
      resp_delay     = 1;
      step();
      redirect_valid = 0;
      check32("drop_resp_ready", {31'd0, mem_resp_ready}, 32'd1);
      check32("drop_no_inst", {31'd0, inst_valid}, 32'd0);
      wait_for(3, base + 1, "after_drop");
      mem_req_ready = 0;
      check32("drop_cnt_1", {16'd0, drop_cnt}, 32'd1);

      // Redirect coincident with the response in WAIT
      base = inst_cnt;
      req_q.push_back(32'h8000_0104);
      mem_req_ready = 1;
      wait_for(2, 0, "resp_redirect");
      redirect_valid = 1;
      redirect_pc    = 32'h8000_0200;
      expect_fetch(32'h8000_0200);
      step();
      redirect_valid = 0;
      check32("coinc_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check32("coinc_addr", mem_req_addr, 32'h8000_0200);
      check32("drop_cnt_2", {16'd0, drop_cnt}, 32'd2);
      wait_for(3, base + 1, "after_coinc");
      mem_req_ready = 0;

      // Redirect in HOLD with inst_ready high
      base = inst_cnt;
      expect_fetch(32'h8000_0204);
      inst_ready    = 0;
      mem_req_ready = 1;
      wait_for(0, 0, "hold_redirect");
      inst_ready     = 1;
      redirect_valid = 1;
      redirect_pc    = 32'h8000_0300;
      expect_fetch(32'h8000_0300);
      step();
      redirect_valid = 0;
      check32("hold_redir_valid", {31'd0, mem_req_valid}, 32'd1);
      check32("hold_redir_addr", mem_req_addr, 32'h8000_0300);
      check32("hold_redir_inst_valid", {31'd0, inst_valid}, 32'd0);
      wait_for(3, base + 2, "after_hold");
      mem_req_ready = 0;
      check32("drop_cnt_still_2", {16'd0, drop_cnt}, 32'd2);

      // Reset pulse during WAIT
      base = inst_cnt;
      req_q.push_back(32'h8000_0304);
      resp_delay    = 3;
      mem_req_ready = 1;
      wait_for(1, 0, "wait_reset");
      rst_n         = 0;
      mem_flush     = 1;
      mem_req_ready = 0;
      step();
      check32("mid_rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      check32("mid_rst_resp_ready", {31'd0, mem_resp_ready}, 32'd0);
      check32("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check32("mid_rst_inst", inst, 32'd0);
      check32("mid_rst_inst_pc", inst_pc, 32'd0);
      check32("mid_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      check32("mid_rst_addr", mem_req_addr, 32'h8000_0000);
      rst_n         = 1;
      mem_flush     = 0;
      resp_delay    = 1;
      expect_fetch(32'h8000_0000);
      mem_req_ready = 1;
      wait_for(3, base + 1, "restart");
      mem_req_ready = 0;

      repeat (4) step();
      check32("req_q_empty", req_q.size(), 32'd0);
      check32("inst_q_empty", inst_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
